// File: rtl/mcs4_ram_bank.sv
// mcs4_ram_bank: NUM_BANKS x CHIPS_PER_BANK 4002-style RAM chips on the MCS-4 bus.
// Ports: clk, rst, sync, cm_ram[bank], dbus_in -> dbus_out/dbus_en (read), io_out.
package mcs4;
  typedef logic [3:0] char_t;
  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, X1, X2, X3
  } instr_cyc_t;
endpackage

module mcs4_ram_bank
  import mcs4::*;
#(
  parameter int NUM_BANKS      = 4,
  parameter int CHIPS_PER_BANK = 4,
  parameter int REGS           = 4,
  parameter int CHARS          = 16,
  parameter int STATUS         = 4,
  parameter int CLEAR_ON_RST   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sync,
  input  logic [NUM_BANKS-1:0]                  cm_ram,
  input  char_t                                 dbus_in,
  output char_t                                 dbus_out,
  output logic                                  dbus_en,
  output logic [NUM_BANKS*CHIPS_PER_BANK*4-1:0] io_out
);

  localparam int NCHIP = NUM_BANKS * CHIPS_PER_BANK;
  localparam int MEMN  = NCHIP * REGS * CHARS;
  localparam int STN   = NCHIP * REGS * STATUS;
  localparam int MW    = (MEMN > 1) ? $clog2(MEMN) : 1;
  localparam int SW    = (STN > 1) ? $clog2(STN) : 1;
  localparam int CW    = (NCHIP > 1) ? $clog2(NCHIP) : 1;

  localparam char_t OP_WRM = 4'h0;
  localparam char_t OP_WMP = 4'h1;
  localparam char_t OP_SBM = 4'h8;
  localparam char_t OP_RDM = 4'h9;
  localparam char_t OP_ADM = 4'hB;

  // Counter: 0..7 are instruction phases, 8..15 idle (saturates at 15).
  logic [3:0] cnt_q, cnt_d;
  instr_cyc_t cyc;
  logic       act;
  logic       is_m2, is_x1, is_x2, is_x3;

  logic [NUM_BANKS-1:0] src_rcvd_q;
  logic [NUM_BANKS-1:0] opa_rcvd_q;
  char_t                addr_hi_q [NUM_BANKS];
  char_t                addr_lo_q [NUM_BANKS];
  char_t                opa_q     [NUM_BANKS];

  char_t mem_q [MEMN];
  char_t st_q  [STN];
  char_t io_q  [NCHIP];

  logic  rd_vld_q;
  char_t rd_dat_q;
  logic  rd_hit;
  char_t rd_val;

  function automatic logic chip_ok(char_t hi);
    return int'(hi[3:2]) < CHIPS_PER_BANK;
  endfunction

  function automatic logic reg_ok(char_t hi);
    return int'(hi[1:0]) < REGS;
  endfunction

  function automatic logic chr_ok(char_t lo);
    return int'(lo) < CHARS;
  endfunction

  function automatic logic st_ok(logic [1:0] n);
    return int'(n) < STATUS;
  endfunction

  function automatic int chip_n(int b, char_t hi);
    return b * CHIPS_PER_BANK + int'(hi[3:2]);
  endfunction

  function automatic logic [MW-1:0] mem_idx(int b, char_t hi, char_t lo);
    return MW'((chip_n(b, hi) * REGS + int'(hi[1:0])) * CHARS
               + int'(lo));
  endfunction

  function automatic logic [SW-1:0] st_idx(int b, char_t hi,
                                           logic [1:0] n);
    return SW'((chip_n(b, hi) * REGS + int'(hi[1:0])) * STATUS
               + int'(n));
  endfunction

  function automatic logic is_rd(char_t op);
    return (op == OP_SBM) || (op == OP_RDM) || (op == OP_ADM)
        || (op[3:2] == 2'b11);
  endfunction

  assign cyc   = instr_cyc_t'(cnt_q[2:0]);
  assign act   = ~cnt_q[3];
  assign is_m2 = act && (cyc == M2);
  assign is_x1 = act && (cyc == X1);
  assign is_x2 = act && (cyc == X2);
  assign is_x3 = act && (cyc == X3);

  always_comb begin
    cnt_d = cnt_q;
    if (sync)
      cnt_d = 4'h0;
    else if (cnt_q != 4'hF)
      cnt_d = cnt_q + 4'h1;
  end

  // Lowest-indexed selected bank with an existing chip supplies the read.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!rd_hit && opa_rcvd_q[b] && is_rd(opa_q[b])
          && chip_ok(addr_hi_q[b])) begin
        rd_hit = 1'b1;
        if (opa_q[b][3:2] == 2'b11) begin
          if (reg_ok(addr_hi_q[b]) && st_ok(opa_q[b][1:0]))
            rd_val = st_q[st_idx(b, addr_hi_q[b], opa_q[b][1:0])];
        end else begin
          if (reg_ok(addr_hi_q[b]) && chr_ok(addr_lo_q[b]))
            rd_val = mem_q[mem_idx(b, addr_hi_q[b], addr_lo_q[b])];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'hF;
      src_rcvd_q <= '0;
      opa_rcvd_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_dat_q   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        addr_hi_q[b] <= '0;
        addr_lo_q[b] <= '0;
        opa_q[b]     <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (is_m2) begin
        opa_rcvd_q <= cm_ram;
        for (int b = 0; b < NUM_BANKS; b++)
          opa_q[b] <= dbus_in;
      end
      if (is_x1) begin
        rd_vld_q <= rd_hit;
        rd_dat_q <= rd_val;
      end
      if (is_x2) begin
        src_rcvd_q <= cm_ram;
        for (int b = 0; b < NUM_BANKS; b++)
          if (cm_ram[b])
            addr_hi_q[b] <= dbus_in;
      end
      if (is_x3) begin
        for (int b = 0; b < NUM_BANKS; b++)
          if (src_rcvd_q[b])
            addr_lo_q[b] <= dbus_in;
      end
    end
  end

  // Writes use the address held before this X2's SRC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) begin
        for (int i = 0; i < MEMN; i++)
          mem_q[i] <= '0;
        for (int i = 0; i < STN; i++)
          st_q[i] <= '0;
        for (int i = 0; i < NCHIP; i++)
          io_q[i] <= '0;
      end
    end else if (is_x2) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (opa_rcvd_q[b] && chip_ok(addr_hi_q[b])) begin
          if (opa_q[b] == OP_WRM && reg_ok(addr_hi_q[b])
              && chr_ok(addr_lo_q[b]))
            mem_q[mem_idx(b, addr_hi_q[b], addr_lo_q[b])] <= dbus_in;
          if (opa_q[b] == OP_WMP)
            io_q[CW'(chip_n(b, addr_hi_q[b]))] <= dbus_in;
          if (opa_q[b][3:2] == 2'b01 && reg_ok(addr_hi_q[b])
              && st_ok(opa_q[b][1:0]))
            st_q[st_idx(b, addr_hi_q[b], opa_q[b][1:0])] <= dbus_in;
        end
      end
    end
  end

  assign dbus_en  = rd_vld_q & is_x2;
  assign dbus_out = dbus_en ? rd_dat_q : '0;

  for (genvar i = 0; i < NCHIP; i++) begin : g_io
    assign io_out[i*4 +: 4] = io_q[i];
  end

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// tb_mcs4_ram_bank: directed + random instruction stream against two
// configurations, checked by an instruction-level memory model.
module tb_mcs4_ram_bank;
  import mcs4::*;

  logic       clk = 1'b0;
  logic       rst, sync;
  logic [3:0] cm_ram;
  char_t      dbus_in;
  char_t      dout0, dout1;
  logic       den0, den1;
  logic [63:0] io0;
  logic [47:0] io1;

  always #5 clk = ~clk;

  mcs4_ram_bank #(.CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst), .sync(sync), .cm_ram(cm_ram),
    .dbus_in(dbus_in), .dbus_out(dout0), .dbus_en(den0), .io_out(io0)
  );

  mcs4_ram_bank #(
    .CHIPS_PER_BANK(3), .CHARS(8), .CLEAR_ON_RST(0)
  ) u1 (
    .clk(clk), .rst(rst), .sync(sync), .cm_ram(cm_ram),
    .dbus_in(dbus_in), .dbus_out(dout1), .dbus_en(den1), .io_out(io1)
  );

  // Model: -1 marks a value never written since power-up (no clear).
  int   mm  [2][4][4][4][16];
  int   st  [2][4][4][4][4];
  int   mio [2][4][4];
  logic [3:0] hi [4];
  logic [3:0] lo [4];
  logic [3:0] src;
  int   npass = 0;
  int   ntot  = 0;
  int   nfail = 0;
  logic en_c  [2][8];
  logic [3:0] out_c [2][8];

  function automatic int cpb(int d);
    return d ? 3 : 4;
  endfunction

  function automatic int nch(int d);
    return d ? 8 : 16;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_rst(input bit pwr);
    for (int b = 0; b < 4; b++) begin
      hi[b] = 0;
      lo[b] = 0;
    end
    src = 0;
    for (int d = 0; d < 2; d++) begin
      if (d == 0 || pwr) begin
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 4; c++) begin
            mio[d][b][c] = d ? -1 : 0;
            for (int r = 0; r < 4; r++) begin
              for (int k = 0; k < 16; k++) mm[d][b][c][r][k] = d ? -1 : 0;
              for (int k = 0; k < 4; k++) st[d][b][c][r][k] = d ? -1 : 0;
            end
          end
      end
    end
  endtask

  // -2: no read; -1: read of unknown value; else the nibble.
  function automatic int exp_rd(int d, logic [3:0] op, logic [3:0] cm);
    int ch, rg;
    if (!(op == 8 || op == 9 || op == 11 || op >= 12)) return -2;
    for (int b = 0; b < 4; b++) begin
      ch = int'(hi[b][3:2]);
      rg = int'(hi[b][1:0]);
      if (cm[b] && ch < cpb(d)) begin
        if (op >= 12) return st[d][b][ch][rg][int'(op) - 12];
        if (int'(lo[b]) >= nch(d)) return 0;
        return mm[d][b][ch][rg][lo[b]];
      end
    end
    return -2;
  endfunction

  task automatic model_wr(logic [3:0] op, logic [3:0] cm, logic [3:0] v);
    int ch, rg;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 4; b++) begin
        ch = int'(hi[b][3:2]);
        rg = int'(hi[b][1:0]);
        if (cm[b] && ch < cpb(d)) begin
          if (op == 0 && int'(lo[b]) < nch(d))
            mm[d][b][ch][rg][lo[b]] = int'(v);
          if (op == 1) mio[d][b][ch] = int'(v);
          if (op >= 4 && op <= 7) st[d][b][ch][rg][int'(op) - 4] = int'(v);
        end
      end
  endtask

  task automatic chk_io(input string tag);
    logic [3:0] o;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < cpb(d); c++)
          if (mio[d][b][c] >= 0) begin
            o = d ? io1[(b*3+c)*4 +: 4] : io0[(b*4+c)*4 +: 4];
            chk($sformatf("%s io%0d[b%0d c%0d]", tag, d, b, c),
                64'(o), 64'(mio[d][b][c]));
          end
  endtask

  task automatic instr(input string tag, input logic [3:0] opr, opa,
                       x2d, x3d, cm2, cmx, input int rph);
    int r [2];
    logic xe;
    logic [3:0] xo;
    sync = 1; rst = 0; cm_ram = 0; dbus_in = 0;
    @(negedge clk);
    @(posedge clk); #1;
    sync = 0;
    for (int p = 0; p < 8; p++) begin
      dbus_in = (p == 3) ? opr : (p == 4) ? opa : (p == 6) ? x2d :
                (p == 7) ? x3d : 4'($urandom);
      cm_ram  = (p == 4) ? cm2 : (p == 6) ? cmx : 4'h0;
      rst     = (p == rph);
      @(negedge clk);
      en_c[0][p] = den0; out_c[0][p] = dout0;
      en_c[1][p] = den1; out_c[1][p] = dout1;
      @(posedge clk); #1;
    end
    rst = 0; cm_ram = 0;
    for (int d = 0; d < 2; d++) begin
      r[d] = (rph <= 5) ? -2 : exp_rd(d, opa, cm2);
      for (int p = 0; p < 8; p++) begin
        xe = (p == 6) && (r[d] != -2);
        xo = (p == 6 && r[d] >= 0) ? 4'(r[d]) : 4'h0;
        chk($sformatf("%s d%0d en@%0d", tag, d, p),
            64'(en_c[d][p]), 64'(xe));
        if (!(p == 6 && r[d] == -1))
          chk($sformatf("%s d%0d out@%0d", tag, d, p),
              64'(out_c[d][p]), 64'(xo));
      end
    end
    if (rph <= 7) model_rst(0);
    else begin
      model_wr(opa, cm2, x2d);
      for (int b = 0; b < 4; b++) if (cmx[b]) hi[b] = x2d;
      src = cmx;
      for (int b = 0; b < 4; b++) if (src[b]) lo[b] = x3d;
    end
    chk_io(tag);
  endtask

  task automatic src_i(input string tag, input logic [3:0] cm, a, c);
    instr(tag, 4'h2, 4'($urandom), a, c, 4'h0, cm, 99);
  endtask

  task automatic io_i(input string tag, input logic [3:0] op, cm, v);
    instr(tag, 4'hE, op, v, 4'($urandom), cm, 4'h0, 99);
  endtask

  initial begin
    rst = 1; sync = 0; cm_ram = 0; dbus_in = 0;
    model_rst(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst en0", 64'(den0), 64'd0);
    chk("rst out0", 64'(dout0), 64'd0);
    chk("rst io0", io0, 64'd0);
    chk("rst en1", 64'(den1), 64'd0);
    @(posedge clk); #1;

    // main memory write/read; also out of range in the CHARS=8 copy
    src_i("src0", 4'b0001, 4'b0110, 4'hA);
    io_i("wrm5", 4'h0, 4'b0001, 4'h5);
    src_i("src0b", 4'b0001, 4'b0110, 4'hA);
    io_i("rdm5", 4'h9, 4'b0001, 4'h0);
    chk("rdm5 val", 64'(out_c[0][6]), 64'h5);
    chk("oor val", 64'(out_c[1][6]), 64'h0);

    // status + output port on bank1 chip2
    src_i("src1", 4'b0010, 4'b1000, 4'h3);
    io_i("wr3", 4'h7, 4'b0010, 4'hC);
    io_i("rd3", 4'hF, 4'b0010, 4'h0);
    chk("rd3 val", 64'(out_c[0][6]), 64'hC);
    io_i("wmp", 4'h1, 4'b0010, 4'h9);
    chk("wmp io", 64'(io0[27:24]), 64'h9);

    // multi-bank broadcast and read priority
    src_i("srcm", 4'b0101, 4'b0001, 4'h3);
    io_i("wrm3", 4'h0, 4'b0101, 4'h3);
    io_i("rdm3", 4'h9, 4'b0100, 4'h0);
    chk("bcast b2", 64'(out_c[0][6]), 64'h3);
    io_i("wrm1", 4'h0, 4'b0001, 4'h1);
    io_i("wrm2", 4'h0, 4'b0100, 4'h2);
    io_i("rdmp", 4'h9, 4'b0101, 4'h0);
    chk("prio val", 64'(out_c[0][6]), 64'h1);

    // no select
    io_i("nosel", 4'h9, 4'b0000, 4'h0);

    // reset during X1 of a write
    instr("rstop", 4'hE, 4'h0, 4'hF, 4'h0, 4'b0001, 4'h0, 5);
    for (int i = 0; i < 16; i++) begin
      cm_ram = 4'($urandom); dbus_in = 4'($urandom);
      @(negedge clk);
      chk($sformatf("idle en0 %0d", i), 64'(den0), 64'd0);
      chk($sformatf("idle en1 %0d", i), 64'(den1), 64'd0);
      @(posedge clk); #1;
    end
    cm_ram = 0;
    src_i("srcr", 4'b0001, 4'b0001, 4'h3);
    io_i("rdmr", 4'h9, 4'b0001, 4'h0);
    chk("cleared", 64'(out_c[0][6]), 64'h0);
    chk("retained", 64'(out_c[1][6]), 64'h1);

    // random instruction stream
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 4)
        instr($sformatf("rs%0d", i), 4'h2, 4'($urandom), 4'($urandom),
              4'($urandom), 4'h0, 4'($urandom), 99);
      else
        instr($sformatf("rio%0d", i), 4'hE, 4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 4'h0,
              ($urandom_range(0, 39) == 0) ? 5 : 99);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
